// File: rtl/pts_pkg.sv
// Shared types and constants for the pair/triple sequencer: FSM state
// encoding, slot indices and the latched verdict record.
package pts_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;

    typedef struct packed {
        logic valid;
        logic pair;
        logic triple;
        logic timeout;
    } result_t;

endpackage

// File: rtl/ptd_cycle_timer.sv
// Free-running cycle timer with clear and enable; tc flags the last count
// (MAX_COUNT-1) so the owner can leave its state before the timer would wrap.
module ptd_cycle_timer #(
    parameter int MAX_COUNT = 10000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    output logic [$clog2(MAX_COUNT)-1:0] value,
    output logic                         tc
);

    localparam int TW = $clog2(MAX_COUNT);
    localparam logic [TW-1:0] LAST = TW'(MAX_COUNT - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (en) begin
            value <= value + 1'b1;
        end
    end

    assign tc = (value == LAST);

endmodule

// File: rtl/pair_triple_sequencer.sv
// Collects three symbols, kicks the pair/triple detector, then latches and
// holds its verdict. Define PTS_TIMEOUT_EN to enable the WAIT-state timeout.
module pair_triple_sequencer
    import pts_pkg::*;
#(
    parameter int MAX_COUNT = 10000,
    parameter int SYM_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             load,
    input  logic             clear,
    output logic             det_start,
    output logic [SYM_W-1:0] det_a,
    output logic [SYM_W-1:0] det_b,
    output logic [SYM_W-1:0] det_c,
    input  logic             det_done,
    input  logic             det_pair,
    input  logic             det_triple,
    output logic             res_valid,
    output logic             res_pair,
    output logic             res_triple,
    output logic             res_timeout,
    output logic [1:0]       count,
    output logic             busy
);

    localparam int TW = $clog2(MAX_COUNT);

    state_t           state, state_nx;
    logic [1:0]       count_nx;
    logic [SYM_W-1:0] slot_a, slot_b, slot_c;
    result_t          res_q, res_nx;
    logic             load_q;
    logic             load_edge;
    logic             cap_en;
    logic [1:0]       cap_idx;
    logic             timer_clr;
    logic             timer_en;
    logic             timer_tc;
    logic [TW-1:0]    timer_value;
    logic             unused_bits;

    assign load_edge = load & ~load_q;

    ptd_cycle_timer #(
        .MAX_COUNT(MAX_COUNT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .value(timer_value),
        .tc   (timer_tc)
    );

    // load_q tracks the pin even while disabled so stale edges are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q <= 1'b0;
            state  <= FILL;
            count  <= 2'd0;
            res_q  <= '0;
            slot_a <= '0;
            slot_b <= '0;
            slot_c <= '0;
        end else begin
            load_q <= load;
            state  <= state_nx;
            count  <= count_nx;
            res_q  <= res_nx;
            if (cap_en) begin
                case (cap_idx)
                    SLOT_A:  slot_a <= sym_in;
                    SLOT_B:  slot_b <= sym_in;
                    SLOT_C:  slot_c <= sym_in;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        res_nx    = res_q;
        cap_en    = 1'b0;
        cap_idx   = SLOT_A;
        timer_clr = 1'b0;
        timer_en  = 1'b0;

        if (clear) begin
            state_nx  = FILL;
            count_nx  = 2'd0;
            res_nx    = '0;
            timer_clr = 1'b1;
        end else if (ena) begin
            case (state)
                FILL: begin
                    timer_clr = 1'b1;
                    if (load_edge) begin
                        cap_en   = 1'b1;
                        cap_idx  = count;
                        count_nx = count + 2'd1;
                        if (count == SLOT_C) begin
                            state_nx = START;
                        end
                    end
                end
                START: begin
                    timer_clr = 1'b1;
                    state_nx  = WAIT;
                end
                WAIT: begin
                    // A verdict arriving on the timeout cycle takes precedence.
                    if (det_done) begin
                        res_nx    = '{valid: 1'b1, pair: det_pair, triple: det_triple, timeout: 1'b0};
                        state_nx  = HOLD;
                        timer_clr = 1'b1;
`ifdef PTS_TIMEOUT_EN
                    end else if (timer_tc) begin
                        res_nx    = '{valid: 1'b1, pair: 1'b0, triple: 1'b0, timeout: 1'b1};
                        state_nx  = HOLD;
                        timer_clr = 1'b1;
                    end else begin
                        timer_en = 1'b1;
                    end
`else
                    end else begin
                        timer_clr = 1'b1;
                    end
`endif
                end
                HOLD: begin
                    // A new load during display starts the next round immediately.
                    if (load_edge) begin
                        res_nx    = '0;
                        cap_en    = 1'b1;
                        cap_idx   = SLOT_A;
                        count_nx  = 2'd1;
                        state_nx  = FILL;
                        timer_clr = 1'b1;
                    end else if (timer_tc) begin
                        res_nx    = '0;
                        count_nx  = 2'd0;
                        state_nx  = FILL;
                        timer_clr = 1'b1;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                default: begin
                    state_nx  = FILL;
                    count_nx  = 2'd0;
                    timer_clr = 1'b1;
                end
            endcase
        end
    end

    assign det_start  = (state == START);
    assign busy       = (state == START) || (state == WAIT);
    assign det_a      = slot_a;
    assign det_b      = slot_b;
    assign det_c      = slot_c;
    assign res_valid  = res_q.valid;
    assign res_pair   = res_q.pair;
    assign res_triple = res_q.triple;
`ifdef PTS_TIMEOUT_EN
    assign res_timeout = res_q.timeout;
`else
    assign res_timeout = 1'b0;
`endif

    assign unused_bits = ^{timer_value, res_q.timeout};

endmodule

// File: tb/tb_pair_triple_sequencer.sv
// Scoreboard bench for pair_triple_sequencer (MAX_COUNT=16, SYM_W=4); the
// timeout cases follow PTS_TIMEOUT_EN when it is defined for the build.
module tb_pair_triple_sequencer;

    localparam int MAX_COUNT = 16;
    localparam int SYM_W     = 4;

    typedef struct {
        logic pair;
        logic triple;
        logic timeout;
        int   lat;
    } res_exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b1;
    logic [SYM_W-1:0] sym_in = '0;
    logic             load = 1'b0;
    logic             clear = 1'b0;
    logic             det_start;
    logic [SYM_W-1:0] det_a, det_b, det_c;
    logic             det_done = 1'b0;
    logic             det_pair = 1'b1;
    logic             det_triple = 1'b1;
    logic             res_valid, res_pair, res_triple, res_timeout;
    logic [1:0]       count;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic prev_valid = 1'b0;

    logic [11:0] start_q[$];
    res_exp_t    res_q[$];

    int   det_delay = 3;
    logic det_enable = 1'b1;
    logic det_pair_v = 1'b0;
    logic det_triple_v = 1'b0;

    pair_triple_sequencer #(
        .MAX_COUNT(MAX_COUNT),
        .SYM_W    (SYM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .sym_in     (sym_in),
        .load       (load),
        .clear      (clear),
        .det_start  (det_start),
        .det_a      (det_a),
        .det_b      (det_b),
        .det_c      (det_c),
        .det_done   (det_done),
        .det_pair   (det_pair),
        .det_triple (det_triple),
        .res_valid  (res_valid),
        .res_pair   (res_pair),
        .res_triple (res_triple),
        .res_timeout(res_timeout),
        .count      (count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [SYM_W-1:0] sym, input int high_cycles);
        @(negedge clk);
        sym_in = sym;
        load   = 1'b1;
        repeat (high_cycles) @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic clearPulse();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic waitRes(input string tag, input int budget);
        int n = 0;
        while (!res_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, res_valid}, 32'd1);
    endtask

    task automatic waitResLow(input string tag, input int budget);
        int n = 0;
        while (res_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, res_valid}, 32'd0);
    endtask

    // Detector model: answers a start pulse after det_delay cycles; verdict
    // lines idle at 1 so stray sampling outside det_done shows up.
    initial begin
        forever begin
            @(negedge clk);
            if (det_start && det_enable) begin
                repeat (det_delay) @(negedge clk);
                det_done   = 1'b1;
                det_pair   = det_pair_v;
                det_triple = det_triple_v;
                @(negedge clk);
                det_done   = 1'b0;
                det_pair   = 1'b1;
                det_triple = 1'b1;
            end
        end
    end

    // Scoreboard monitor: slots checked at each start pulse, verdict and
    // latency (cycles from the start pulse) when res_valid rises.
    always @(negedge clk) begin
        if (!rst) begin
            if (det_start) begin
                start_cyc = cyc;
                checkOutput("start_expected", {31'd0, start_q.size() > 0}, 32'd1);
                if (start_q.size() > 0) begin
                    checkOutput("start_slots", {20'd0, det_a, det_b, det_c}, {20'd0, start_q.pop_front()});
                end
            end
            if (res_valid && !prev_valid) begin
                checkOutput("result_expected", {31'd0, res_q.size() > 0}, 32'd1);
                if (res_q.size() > 0) begin
                    res_exp_t e;
                    e = res_q.pop_front();
                    checkOutput("res_verdict", {29'd0, res_pair, res_triple, res_timeout},
                                {29'd0, e.pair, e.triple, e.timeout});
                    checkOutput("res_latency", cyc - start_cyc, e.lat);
                end
            end
            prev_valid = res_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int guard;

        repeat (3) @(negedge clk);
        checkOutput("rst_count", {30'd0, count}, 32'd0);
        checkOutput("rst_outputs", {25'd0, det_start, busy, res_valid, res_pair, res_triple, res_timeout, 1'b0}, 32'd0);
        checkOutput("rst_slots", {20'd0, det_a, det_b, det_c}, 32'd0);
        rst = 1'b0;

        // Round 1: triple 5/5/5, verdict three cycles after start, full hold.
        $display("[TB] round 1: triple");
        det_enable = 1'b1; det_delay = 3; det_pair_v = 1'b0; det_triple_v = 1'b1;
        start_q.push_back({4'd5, 4'd5, 4'd5});
        res_q.push_back('{pair: 1'b0, triple: 1'b1, timeout: 1'b0, lat: 4});
        applyStimulus(4'd5, 1);
        applyStimulus(4'd5, 1);
        applyStimulus(4'd5, 1);
        checkOutput("r1_count_busy", {29'd0, count, busy}, {29'd0, 2'd3, 1'b1});
        waitRes("r1_res_arrives", 20);
        n = 0; guard = 0;
        while (res_valid && guard < 40) begin
            n++;
            @(negedge clk);
            guard++;
        end
        checkOutput("r1_hold_len", n, MAX_COUNT);
        checkOutput("r1_after_hold", {29'd0, count, res_triple}, 32'd0);

        // Round 2: pair 3/7/3 with a long first load; clear during hold.
        $display("[TB] round 2: pair, long load, clear in hold");
        det_delay = 2; det_pair_v = 1'b1; det_triple_v = 1'b0;
        start_q.push_back({4'd3, 4'd7, 4'd3});
        res_q.push_back('{pair: 1'b1, triple: 1'b0, timeout: 1'b0, lat: 3});
        applyStimulus(4'd3, 10);
        checkOutput("r2_long_load_count", {30'd0, count}, 32'd1);
        applyStimulus(4'd7, 1);
        applyStimulus(4'd3, 1);
        waitRes("r2_res_arrives", 20);
        repeat (2) @(negedge clk);
        clearPulse();
        checkOutput("r2_clear_in_hold", {28'd0, res_valid, res_pair, count}, 32'd0);

        // Edges while disabled are lost.
        ena = 1'b0;
        applyStimulus(4'd7, 1);
        ena = 1'b1;
        @(negedge clk);
        checkOutput("ena_lost_edge_count", {30'd0, count}, 32'd0);
        checkOutput("ena_slot_hold", {28'd0, det_a}, 32'd3);

        // Round 3: no verdict.
        $display("[TB] round 3: no detector response");
        det_enable = 1'b0;
        start_q.push_back({4'd1, 4'd2, 4'd3});
`ifdef PTS_TIMEOUT_EN
        res_q.push_back('{pair: 1'b0, triple: 1'b0, timeout: 1'b1, lat: MAX_COUNT + 1});
`endif
        applyStimulus(4'd1, 1);
        applyStimulus(4'd2, 1);
        applyStimulus(4'd3, 1);
`ifdef PTS_TIMEOUT_EN
        waitRes("r3_timeout_arrives", 40);
        waitResLow("r3_hold_ends", 40);
`else
        repeat (120) @(negedge clk);
        checkOutput("r3_wait_persists", {30'd0, busy, res_valid}, 32'd2);
        clearPulse();
        checkOutput("r3_clear_exits", {30'd0, busy, res_timeout}, 32'd0);
`endif

        // Round 4: verdict on the would-be timeout cycle wins.
        $display("[TB] round 4: verdict on timeout cycle");
        det_enable = 1'b1; det_delay = MAX_COUNT; det_pair_v = 1'b1; det_triple_v = 1'b0;
        start_q.push_back({4'd6, 4'd6, 4'd1});
        res_q.push_back('{pair: 1'b1, triple: 1'b0, timeout: 1'b0, lat: MAX_COUNT + 1});
        applyStimulus(4'd6, 1);
        applyStimulus(4'd6, 1);
        applyStimulus(4'd1, 1);
        waitRes("r4_res_arrives", 40);
        waitResLow("r4_hold_ends", 40);

        // Round 5a: clear during WAIT.
        $display("[TB] round 5: clear in wait and on third load");
        det_enable = 1'b0;
        start_q.push_back({4'd4, 4'd5, 4'd6});
        applyStimulus(4'd4, 1);
        applyStimulus(4'd5, 1);
        applyStimulus(4'd6, 1);
        repeat (5) @(negedge clk);
        checkOutput("r5a_in_wait", {31'd0, busy}, 32'd1);
        clearPulse();
        checkOutput("r5a_after_clear", {26'd0, count, busy, res_valid, res_pair, res_triple, res_timeout}, 32'd0);
        checkOutput("r5a_slots_kept", {20'd0, det_a, det_b, det_c}, {20'd0, 4'd4, 4'd5, 4'd6});

        // Round 5b: clear coincident with the third load edge.
        applyStimulus(4'd1, 1);
        applyStimulus(4'd2, 1);
        @(negedge clk);
        sym_in = 4'd8; load = 1'b1; clear = 1'b1;
        @(negedge clk);
        load = 1'b0; clear = 1'b0;
        checkOutput("r5b_after_clear", {26'd0, count, busy, det_start, res_valid, res_pair, res_timeout}, 32'd0);
        checkOutput("r5b_slot_c_kept", {28'd0, det_c}, 32'd6);
        repeat (4) @(negedge clk);
        checkOutput("r5b_no_start", {31'd0, busy}, 32'd0);

        // Round 6a: new load during hold starts the next round.
        $display("[TB] round 6: reload in hold, ena freeze in wait");
        det_enable = 1'b1; det_delay = 1; det_pair_v = 1'b1; det_triple_v = 1'b0;
        start_q.push_back({4'd2, 4'd2, 4'd2});
        res_q.push_back('{pair: 1'b1, triple: 1'b0, timeout: 1'b0, lat: 2});
        applyStimulus(4'd2, 1);
        applyStimulus(4'd2, 1);
        applyStimulus(4'd2, 1);
        waitRes("r6a_res_arrives", 20);
        repeat (2) @(negedge clk);
        applyStimulus(4'd9, 1);
        checkOutput("r6a_reload_res", {30'd0, res_valid, res_pair}, 32'd0);
        checkOutput("r6a_reload_count", {30'd0, count}, 32'd1);
        checkOutput("r6a_reload_slots", {24'd0, det_a, det_b}, {24'd0, 4'd9, 4'd2});
        clearPulse();
        checkOutput("r6a_cleared", {30'd0, count}, 32'd0);

`ifdef PTS_TIMEOUT_EN
        // Round 6b: five disabled cycles in WAIT push the timeout out by five.
        det_enable = 1'b0;
        start_q.push_back({4'd1, 4'd1, 4'd2});
        res_q.push_back('{pair: 1'b0, triple: 1'b0, timeout: 1'b1, lat: MAX_COUNT + 6});
        applyStimulus(4'd1, 1);
        applyStimulus(4'd1, 1);
        applyStimulus(4'd2, 1);
        repeat (3) @(negedge clk);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        ena = 1'b1;
        waitRes("r6b_timeout_arrives", 40);
        waitResLow("r6b_hold_ends", 40);
`endif

        repeat (2) @(negedge clk);
        checkOutput("sb_start_q_empty", start_q.size(), 32'd0);
        checkOutput("sb_res_q_empty", res_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pair_triple_sequencer.md
# pair_triple_sequencer

Controller that sequences the pair/triple detector inside the TinyTapeout user design. It collects three symbols from a debounced load strobe and presents them to the detector with a one-cycle start pulse. It then waits for the detector's done or for a timeout, latches and holds the verdict for display, and re-arms for the next round.

## Interface
Parameters:
- MAX_COUNT, 10000: cycles for the WAIT timeout and for the HOLD display time; legal range ≥2.
- SYM_W, 4: symbol width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- ena  in  1  design enable; low freezes all state
- sym_in  in  SYM_W  symbol to capture
- load  in  1  capture request, level; rising edge detected internally
- clear  in  1  abort round, level; acts on every cycle it is high
- det_start  out  1  one-cycle start pulse to the detector
- det_a, det_b, det_c  out  SYM_W  captured slots 0/1/2 presented to the detector
- det_done  in  1  detector verdict valid
- det_pair, det_triple  in  1  detector verdict
- res_valid  out  1  result held
- res_pair, res_triple, res_timeout  out  1  latched verdict
- count  out  2  symbols captured this round (0–3)
- busy  out  1  high in START or WAIT

## Operation
- Reset values: state FILL, count 0, slots 0, load_q 0, timer 0, all outputs 0.
- Edge detect: `load_edge = load & ~load_q`. load_q samples load on every clock edge, including when ena=0. Edges that occur while ena=0 are lost.
- ena=0: state, slots, count, timer and results hold.
- Priority in each cycle: rst > clear > ena gating > FSM.
- clear: from any state, go to FILL with count 0. Results and timer clear. Slots keep their values. A load_edge in the same cycle is ignored.
- FILL:
  - On load_edge, slot[count] ← sym_in and count++.
  - When the capture makes count reach 3, go to START.
- START:
  - det_start=1 for exactly one cycle.
  - Timer clears.
  - Go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If det_done=1: res_pair ← det_pair, res_triple ← det_triple, res_timeout ← 0, res_valid ← 1. Go to HOLD and clear the timer.
  - Else if timer == MAX_COUNT-1: res_timeout ← 1, pair/triple ← 0, res_valid ← 1. Go to HOLD.
  - If det_done and timeout occur in the same cycle, det_done wins.
  - load_edge is ignored in WAIT.
- HOLD:
  - Results are stable.
  - Timer increments. At timer == MAX_COUNT-1, go to FILL, count ← 0, res_* ← 0.
  - load_edge during HOLD clears results, captures sym_in into slot 0 with count=1, and goes to FILL.
- det_a/b/c always reflect the slot registers. They are stable from START until the next capture.
- det_pair and det_triple are sampled only on a det_done cycle.
- Timer width is $clog2(MAX_COUNT). The timer never wraps: it clears on every state entry.

## Timing
- Capture: slot and count update on the clock edge where load_edge=1.
- Third capture edge → det_start high in the next cycle (latency 1).
- det_done sampled high at edge N → res_valid high from edge N. HOLD lasts MAX_COUNT cycles.
- No det_done: res_timeout rises MAX_COUNT cycles after the START cycle.
- busy = (state==START || state==WAIT), decoded combinationally from the state register.
- clear or rst asserted at edge N → outputs at reset values after edge N.

## Configuration
- PTS_TIMEOUT_EN defined: WAIT timeout as described.
- PTS_TIMEOUT_EN undefined:
  - WAIT exits only on det_done or clear.
  - res_timeout is tied 0.
  - The timer is used only for HOLD.

## Structure
- Shared package pts_pkg holds:
  - the state enum typedef (FILL, START, WAIT, HOLD);
  - the slot index constants;
  - the packed result struct {valid, pair, triple, timeout}.
- One sub-module: ptd_cycle_timer (parameter MAX_COUNT; inputs clk, rst, clr, en; outputs value, tc where tc = value==MAX_COUNT-1). It is used by both WAIT and HOLD.

## Test plan
Run with MAX_COUNT=16 and SYM_W=4.
1. Load 5, 5, 5 with ena=1; detector returns done with triple=1 three cycles after start → det_start is one pulse the cycle after the third load; det_a/b/c=5/5/5; res_triple=1, res_valid=1 for 16 cycles; then count=0.
2. Load 3, 7, 3; det_pair=1 → res_pair=1, res_triple=0. Holding load high for 10 cycles counts as one capture only.
3. Load 1, 2, 3 with det_done never asserted → res_timeout=1 exactly 16 cycles after the det_start cycle. With PTS_TIMEOUT_EN undefined, WAIT persists past 100 cycles.
4. det_done asserted on the timeout cycle → res_timeout=0 and the detector verdict is latched.
5. clear during WAIT, and separately clear coincident with the third load edge → FILL with count=0, no det_start, and res_* all 0.
6. In HOLD, load edge with sym_in=9 → res_valid drops, count=1, det_a=9. A separate case: ena=0 for 5 cycles mid-WAIT extends the timeout by exactly 5 cycles.
